// File: rtl/axil_arb_pkg.sv
// Shared types and constants for the AXI-Lite write arbiter.
package axil_arb_pkg;

  localparam int W_DATA = 32;

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_ADDR   = 3'd1,
    S_DATA   = 3'd2,
    S_RESP   = 3'd3,
    S_RETURN = 3'd4
  } state_t;

endpackage

// File: rtl/rr_arbiter.sv
// Combinational rotating-priority pick: first set request after 'last', wrapping around.
module rr_arbiter #(
  parameter int NUM_REQ = 4,
  localparam int IDX_W = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [IDX_W-1:0]   last,
  output logic [IDX_W-1:0]   grant,
  output logic               grant_vld
);

  int idx;

  // Scan from the farthest offset down so the nearest eligible requester overwrites the rest.
  always_comb begin
    grant     = '0;
    grant_vld = 1'b0;
    idx       = 0;
    for (int off = NUM_REQ; off >= 1; off--) begin
      idx = (int'(last) + off) % NUM_REQ;
      if (req[idx]) begin
        grant     = IDX_W'(idx);
        grant_vld = 1'b1;
      end
    end
  end

endmodule

// File: rtl/axil_wr_arbiter.sv
// Round-robin share of one AXI-Lite write slave among NUM_REQ requesters, one
// transaction in flight, AW -> W -> B sequenced downstream, with a per-phase watchdog.
module axil_wr_arbiter
  import axil_arb_pkg::*;
#(
  parameter int NUM_REQ = 4,
  parameter int ADDR_W  = 4,
  parameter int TIMEOUT = 256,
  localparam int IDX_W  = $clog2(NUM_REQ)
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic [NUM_REQ*ADDR_W-1:0]   req_awaddr,
  input  logic [NUM_REQ-1:0]          req_awvalid,
  output logic [NUM_REQ-1:0]          req_awready,
  input  logic [NUM_REQ*W_DATA-1:0]   req_wdata,
  input  logic [NUM_REQ-1:0]          req_wvalid,
  output logic [NUM_REQ-1:0]          req_wready,
  output logic [NUM_REQ-1:0]          req_bvalid,
  input  logic [NUM_REQ-1:0]          req_bready,
  output logic [ADDR_W-1:0]           m_awaddr,
  output logic                        m_awvalid,
  input  logic                        m_awready,
  output logic [W_DATA-1:0]           m_wdata,
  output logic                        m_wvalid,
  input  logic                        m_wready,
  input  logic                        m_bvalid,
  output logic                        m_bready,
  output logic [IDX_W-1:0]            grant_id,
  output logic                        busy,
  output logic                        timeout
);

  localparam int CNT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);

  state_t               state_q, state_d;
  logic [IDX_W-1:0]     last_q;
  logic [IDX_W-1:0]     grant_w;
  logic                 grant_vld;
  logic                 accept, hs, in_phase, expire;
  logic [CNT_W-1:0]     cnt_q;
  logic [NUM_REQ-1:0]   eligible;

  // A requester only competes once both its address and data are offered.
  assign eligible = req_awvalid & req_wvalid;

  rr_arbiter #(.NUM_REQ(NUM_REQ)) u_rr (
    .req       (eligible),
    .last      (last_q),
    .grant     (grant_w),
    .grant_vld (grant_vld)
  );

  always_ff @(posedge clk) begin
    if (rst) state_q <= S_IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d  = state_q;
    accept   = 1'b0;
    hs       = 1'b0;
    in_phase = 1'b0;
    case (state_q)
      S_IDLE:   if (grant_vld) begin
                  accept  = 1'b1;
                  state_d = S_ADDR;
                end
      S_ADDR:   begin in_phase = 1'b1; hs = m_awready; end
      S_DATA:   begin in_phase = 1'b1; hs = m_wready;  end
      S_RESP:   begin in_phase = 1'b1; hs = m_bvalid;  end
      S_RETURN: if (req_bready[grant_id]) state_d = S_IDLE;
      default:  state_d = S_IDLE;
    endcase
    // A handshake landing on the expiry cycle takes precedence over the abort.
    expire = (TIMEOUT != 0) && in_phase && !hs && (cnt_q == CNT_LAST);
    if (in_phase && hs)
      state_d = (state_q == S_ADDR) ? S_DATA : (state_q == S_DATA) ? S_RESP : S_RETURN;
    else if (expire)
      state_d = S_RETURN;
  end

  always_comb begin
    req_awready = '0;
    if (accept) req_awready[grant_w] = 1'b1;
  end
  assign req_wready = req_awready;
  assign busy       = (state_q != S_IDLE);

  always_ff @(posedge clk) begin
    if (rst) begin
      last_q     <= IDX_W'(NUM_REQ - 1);
      grant_id   <= '0;
      m_awaddr   <= '0;
      m_wdata    <= '0;
      m_awvalid  <= 1'b0;
      m_wvalid   <= 1'b0;
      m_bready   <= 1'b0;
      req_bvalid <= '0;
      timeout    <= 1'b0;
      cnt_q      <= '0;
    end else begin
      timeout <= expire;
      if (state_d != state_q || !in_phase) cnt_q <= '0;
      else                                 cnt_q <= cnt_q + CNT_W'(1);
      if (accept) begin
        m_awaddr  <= req_awaddr[grant_w*ADDR_W +: ADDR_W];
        m_wdata   <= req_wdata[grant_w*W_DATA +: W_DATA];
        grant_id  <= grant_w;
        last_q    <= grant_w;
        m_awvalid <= 1'b1;
      end
      if (in_phase && hs) begin
        case (state_q)
          S_ADDR:  begin m_awvalid <= 1'b0; m_wvalid <= 1'b1; end
          S_DATA:  begin m_wvalid  <= 1'b0; m_bready <= 1'b1; end
          default: begin m_bready  <= 1'b0; req_bvalid[grant_id] <= 1'b1; end
        endcase
      end
      // Aborted transactions still return a response so the requester never stalls.
      if (expire) begin
        m_awvalid            <= 1'b0;
        m_wvalid             <= 1'b0;
        m_bready             <= 1'b0;
        req_bvalid[grant_id] <= 1'b1;
      end
      if (state_q == S_RETURN && req_bready[grant_id]) req_bvalid[grant_id] <= 1'b0;
    end
  end

endmodule

// File: tb/tb_axil_wr_arbiter.sv
// Randomised and directed bench for axil_wr_arbiter with a transaction-level
// reference model feeding a scoreboard that a separate monitor drains.
module tb_axil_wr_arbiter;

  localparam int N  = 4;
  localparam int AW = 4;
  localparam int TO = 16;

  logic              clk = 1'b0;
  logic              rst;
  logic [N*AW-1:0]   req_awaddr;
  logic [N-1:0]      req_awvalid, req_awready;
  logic [N*32-1:0]   req_wdata;
  logic [N-1:0]      req_wvalid, req_wready, req_bvalid, req_bready;
  logic [AW-1:0]     m_awaddr;
  logic              m_awvalid, m_awready;
  logic [31:0]       m_wdata;
  logic              m_wvalid, m_wready, m_bvalid, m_bready;
  logic [1:0]        grant_id;
  logic              busy, timeout;

  axil_wr_arbiter #(.NUM_REQ(N), .ADDR_W(AW), .TIMEOUT(TO)) dut (
    .clk(clk), .rst(rst),
    .req_awaddr(req_awaddr), .req_awvalid(req_awvalid), .req_awready(req_awready),
    .req_wdata(req_wdata), .req_wvalid(req_wvalid), .req_wready(req_wready),
    .req_bvalid(req_bvalid), .req_bready(req_bready),
    .m_awaddr(m_awaddr), .m_awvalid(m_awvalid), .m_awready(m_awready),
    .m_wdata(m_wdata), .m_wvalid(m_wvalid), .m_wready(m_wready),
    .m_bvalid(m_bvalid), .m_bready(m_bready),
    .grant_id(grant_id), .busy(busy), .timeout(timeout)
  );

  always #5 clk = ~clk;

  // Slave modes: 0 zero-wait, 1 random bounded waits, 2 hung, 3 W ready exactly at expiry, 4 W never ready.
  typedef struct {
    int          idx;
    logic [AW-1:0] addr;
    logic [31:0] data;
    int          mode;
    longint      acc;
  } txn_t;

  txn_t         exp_q[$];
  int           acc_log[$];
  int           checks = 0, errors = 0;
  int           slv_mode = 0;
  bit           rand_req = 0, refill = 0, finish_req = 0;
  bit           m_free = 1;
  int           m_last = N - 1;
  longint       cyc = 0;
  int           stall = 0;
  bit           prev_wait = 0;
  logic [N-1:0] acc_seen = '0;
  int           aw_cyc = 0, wv_cyc = 0, to_cnt = 0;
  longint       b_first = -1;
  int           rr_exp[5] = '{0, 1, 2, 3, 0};

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic post(input int i, input logic [AW-1:0] a, input logic [31:0] d,
                      input bit aw, input bit wv);
    req_awaddr[i*AW +: AW] = a;
    req_wdata[i*32 +: 32]  = d;
    req_awvalid[i]         = aw;
    req_wvalid[i]          = wv;
  endtask

  // One clock of stimulus: slave responses and requester traffic, driven just after the edge.
  task automatic tick();
    bit go;
    @(posedge clk);
    #1;
    cyc++;
    if (prev_wait) stall++;
    else           stall = 0;
    go = (slv_mode == 0) || (slv_mode == 1 && ($urandom_range(0, 1) == 1 || stall >= 5));
    m_awready = m_awvalid && (go || slv_mode == 3 || slv_mode == 4);
    m_wready  = m_wvalid && (go || (slv_mode == 3 && stall == 15));
    m_bvalid  = m_bready && (go || slv_mode == 3);
    prev_wait = (m_awvalid || m_wvalid || m_bready) &&
                !((m_awvalid && m_awready) || (m_wvalid && m_wready) || (m_bready && m_bvalid));
    req_bready = rand_req ? N'($urandom) : '1;
    for (int i = 0; i < N; i++) begin
      if (acc_seen[i]) begin
        req_awvalid[i] = 1'b0;
        req_wvalid[i]  = 1'b0;
        if (refill) post(i, AW'($urandom), $urandom, 1'b1, 1'b1);
      end else if (rand_req) begin
        if (!req_awvalid[i] && !req_wvalid[i]) begin
          if ($urandom_range(0, 3) == 0)
            post(i, AW'($urandom), $urandom, $urandom_range(0, 3) != 0, $urandom_range(0, 3) != 0);
        end else begin
          if ($urandom_range(0, 1) == 1) req_awvalid[i] = 1'b1;
          if ($urandom_range(0, 1) == 1) req_wvalid[i]  = 1'b1;
        end
      end else if (finish_req && (req_awvalid[i] || req_wvalid[i])) begin
        req_awvalid[i] = 1'b1;
        req_wvalid[i]  = 1'b1;
      end
    end
    acc_seen = '0;
  endtask

  task automatic wait_idle(input int max_cyc);
    int  n = 0;
    bit  done;
    done = 1'b0;
    while (n < max_cyc && !done) begin
      tick();
      n++;
      done = (exp_q.size() == 0) && m_free && ((req_awvalid | req_wvalid) == '0);
    end
    chk("idle_wait", done, 1);
  endtask

  task automatic chk_quiet(input string tag);
    chk({tag, "_m_awvalid"}, m_awvalid, 0);
    chk({tag, "_m_wvalid"}, m_wvalid, 0);
    chk({tag, "_m_bready"}, m_bready, 0);
    chk({tag, "_req_bvalid"}, req_bvalid, 0);
    chk({tag, "_req_awready"}, req_awready, 0);
    chk({tag, "_busy"}, busy, 0);
    chk({tag, "_timeout"}, timeout, 0);
    chk({tag, "_m_awaddr"}, m_awaddr, 0);
    chk({tag, "_m_wdata"}, m_wdata, 0);
    chk({tag, "_grant_id"}, grant_id, 0);
  endtask

  always @(negedge clk) acc_seen = req_awready & req_awvalid & req_wvalid;

  // Reference model: the arbiter is either free or holding one transaction; when free,
  // the first requester offering both AW and W after the last winner is taken.
  always @(negedge clk) begin
    if (!rst) begin
      logic [N-1:0] elig, exp_rdy;
      int           w;
      txn_t         t;
      elig    = req_awvalid & req_wvalid;
      exp_rdy = '0;
      w       = -1;
      if (m_free)
        for (int off = 1; off <= N; off++)
          if (w < 0 && elig[(m_last + off) % N]) w = (m_last + off) % N;
      if (w >= 0) exp_rdy[w] = 1'b1;
      chk("req_awready", req_awready, exp_rdy);
      chk("req_wready", req_wready, exp_rdy);
      chk("busy", busy, !m_free);
      if (w >= 0) begin
        t.idx  = w;
        t.addr = req_awaddr[w*AW +: AW];
        t.data = req_wdata[w*32 +: 32];
        t.mode = slv_mode;
        t.acc  = cyc;
        exp_q.push_back(t);
        acc_log.push_back(w);
        m_free = 1'b0;
        m_last = w;
      end
      if ((req_bvalid & req_bready) != '0) m_free = 1'b1;
    end
  end

  // Monitor: compares every downstream handshake and every returned response with the scoreboard.
  always @(negedge clk) begin
    if (rst) begin
      aw_cyc = 0; wv_cyc = 0; to_cnt = 0; b_first = -1;
    end else begin
      txn_t t;
      if (m_awvalid) aw_cyc++;
      if (m_wvalid)  wv_cyc++;
      if (timeout)   to_cnt++;
      if (req_bvalid != '0 && b_first < 0) b_first = cyc;
      if (m_awvalid && m_awready) begin
        if (exp_q.size() == 0) chk("aw_unexpected", 1, 0);
        else                   chk("m_awaddr", m_awaddr, exp_q[0].addr);
      end
      if (m_wvalid && m_wready) begin
        if (exp_q.size() == 0) chk("w_unexpected", 1, 0);
        else                   chk("m_wdata", m_wdata, exp_q[0].data);
      end
      if ((req_bvalid & req_bready) != '0) begin
        if (exp_q.size() == 0) chk("b_unexpected", 1, 0);
        else begin
          t = exp_q.pop_front();
          chk("b_route", req_bvalid, 4'b0001 << t.idx);
          chk("grant_id", grant_id, t.idx);
          chk("timeout_pulses", to_cnt, (t.mode == 2) ? 1 : 0);
          if (t.mode == 2) chk("aw_cycles_to_abort", aw_cyc, TO);
          if (t.mode == 3) chk("w_cycles_at_expiry", wv_cyc, TO);
          if (t.mode == 0) chk("b_latency", b_first - t.acc, 4);
          aw_cyc = 0; wv_cyc = 0; to_cnt = 0; b_first = -1;
        end
      end
    end
  end

  initial begin
    rst = 1'b1;
    req_awaddr = '0; req_wdata = '0; req_awvalid = '0; req_wvalid = '0; req_bready = '1;
    m_awready = 1'b0; m_wready = 1'b0; m_bvalid = 1'b0;
    repeat (3) tick();
    @(negedge clk);
    chk_quiet("reset");
    tick();
    rst = 1'b0;

    // All four requesters eligible continuously.
    refill = 1;
    for (int i = 0; i < N; i++) post(i, AW'($urandom), $urandom, 1'b1, 1'b1);
    for (int n = 0; n < 200 && acc_log.size() < 5; n++) tick();
    refill = 0;
    wait_idle(200);
    chk("rr_count", acc_log.size() >= 5, 1);
    if (acc_log.size() >= 5)
      for (int k = 0; k < 5; k++) chk("rr_order", acc_log[k], rr_exp[k]);

    // Single requester 2, zero-wait slave.
    acc_log.delete();
    post(2, 4'h5, 32'hDEADBEEF, 1'b1, 1'b1);
    wait_idle(50);
    chk("t1_grant", (acc_log.size() > 0) ? acc_log[0] : -1, 2);
    chk("t1_m_awaddr", m_awaddr, 4'h5);
    chk("t1_m_wdata", m_wdata, 32'hDEADBEEF);

    // AW without W is never granted.
    acc_log.delete();
    post(1, 4'hA, 32'h1234_5678, 1'b1, 1'b0);
    repeat (10) tick();
    chk("aw_only_grants", acc_log.size(), 0);
    req_wvalid[1] = 1'b1;
    for (int n = 0; n < 5 && acc_log.size() == 0; n++) tick();
    chk("aw_w_grant", (acc_log.size() > 0) ? acc_log[0] : -1, 1);
    wait_idle(50);

    // Hung slave: watchdog aborts in ADDR, then normal traffic resumes.
    acc_log.delete();
    slv_mode = 2;
    post(0, 4'h3, $urandom, 1'b1, 1'b1);
    wait_idle(100);
    slv_mode = 0;
    post(3, 4'hC, $urandom, 1'b1, 1'b1);
    wait_idle(50);
    chk("after_timeout_grant", (acc_log.size() == 2) ? acc_log[1] : -1, 3);

    // W handshake on the expiry cycle.
    slv_mode = 3;
    post(1, 4'h7, $urandom, 1'b1, 1'b1);
    wait_idle(100);

    // Reset while in DATA.
    slv_mode = 4;
    post(3, 4'h9, $urandom, 1'b1, 1'b1);
    for (int n = 0; n < 20 && !m_wvalid; n++) tick();
    chk("reach_data", m_wvalid, 1);
    rst = 1'b1;
    req_awvalid = '0; req_wvalid = '0;
    exp_q.delete(); acc_log.delete();
    m_free = 1'b1; m_last = N - 1;
    tick();
    @(negedge clk);
    chk_quiet("mid_reset");
    tick();
    rst = 1'b0;
    slv_mode = 0;
    for (int i = 0; i < N; i++) post(i, AW'($urandom), $urandom, 1'b1, 1'b1);
    tick();
    chk("post_reset_first", (acc_log.size() > 0) ? acc_log[0] : -1, 0);
    wait_idle(200);

    // Randomised traffic with a randomly stalling slave and requesters.
    acc_log.delete();
    rand_req = 1; slv_mode = 1;
    repeat (1500) tick();
    rand_req = 0; finish_req = 1;
    wait_idle(1000);
    finish_req = 0;
    chk("drain", exp_q.size(), 0);
    chk("random_grants", acc_log.size() > 20, 1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
